// File: rtl/l2_mem_pkg.sv
// Shared types and constants for the L2 memory responder.
package l2_mem_pkg;

    localparam int WORD_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int BEAT_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        RD_DONE,
        WR_WAIT,
        WR_GRANT
    } l2_rsp_state_t;

endpackage

// File: rtl/l2_mem_responder_if.sv
// L1 miss-handler <-> L2 responder bus. The master is the miss handler, the slave is the responder.
interface l2_mem_responder_if;
    import l2_mem_pkg::*;

    // A read beat transfers on every cycle with rd_en && rd_granted; a write lands on every
    // cycle with wr_en && wr_granted. rd_en/wr_req are held until granted and dropping one
    // withdraws the request (or ends the grant). rd_data follows any rd_en cycle by one clock.
    logic                rd_en;
    logic                wr_req;
    logic                wr_en;
    logic [WORD_W-1:0]   addr;
    logic [WORD_W-1:0]   wr_data;
    logic [WORD_W-1:0]   rd_data;
    logic                rd_granted;
    logic                wr_granted;
    logic                busy;
    l2_rsp_state_t       dbg_state;

    modport master (
        output rd_en, wr_req, wr_en, addr, wr_data,
        input  rd_data, rd_granted, wr_granted, busy, dbg_state
    );

    modport slave (
        input  rd_en, wr_req, wr_en, addr, wr_data,
        output rd_data, rd_granted, wr_granted, busy, dbg_state
    );

endinterface

// File: rtl/l2_mem_array.sv
// Synchronous 1R1W word RAM with a registered read port; a same-cycle write/read returns old data.
module l2_mem_array
    import l2_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/l2_mem_responder.sv
// L2-side responder: grants the L1 bus to one read burst or write-through at a time.
module l2_mem_responder
    import l2_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int GRANT_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_mem_responder_if.slave bus
);

    localparam int DLY_W = (GRANT_DLY > 1) ? $clog2(GRANT_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((GRANT_DLY > 0) ? GRANT_DLY - 1 : 0);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    // With no grant delay the wait states are skipped so the grant still lands one cycle after the request.
    localparam l2_rsp_state_t RD_FIRST = (GRANT_DLY == 0) ? RD_BURST : RD_WAIT;
    localparam l2_rsp_state_t WR_FIRST = (GRANT_DLY == 0) ? WR_GRANT : WR_WAIT;

    l2_rsp_state_t     state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [DLY_W-1:0]  dly_cnt, dly_nxt;
    logic              mem_we;
    logic              unused_addr_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            dly_cnt  <= dly_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        dly_nxt   = dly_cnt;
        case (state)
            IDLE: begin
                if (bus.rd_en) begin
                    state_nxt = RD_FIRST;
                end else if (bus.wr_req) begin
                    state_nxt = WR_FIRST;
                end
            end
            RD_WAIT: begin
                if (!bus.rd_en) begin
                    state_nxt = IDLE;
                    dly_nxt   = '0;
                end else if (dly_cnt == DLY_LAST) begin
                    state_nxt = RD_BURST;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + DLY_W'(1);
                end
            end
            RD_BURST: begin
                if (!bus.rd_en) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat_cnt + BEAT_W'(1);
                    if (beat_cnt == BEAT_LAST) begin
                        state_nxt = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                state_nxt = IDLE;
            end
            WR_WAIT: begin
                if (!bus.wr_req) begin
                    state_nxt = IDLE;
                    dly_nxt   = '0;
                end else if (dly_cnt == DLY_LAST) begin
                    state_nxt = WR_GRANT;
                    dly_nxt   = '0;
                end else begin
                    dly_nxt = dly_cnt + DLY_W'(1);
                end
            end
            WR_GRANT: begin
                if (!bus.wr_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
                dly_nxt   = '0;
            end
        endcase
    end

    // Grants decode straight from the state register, so they are glitch-free Moore outputs.
    assign bus.rd_granted = (state == RD_BURST);
    assign bus.wr_granted = (state == WR_GRANT);
    assign bus.busy       = (state != IDLE);
    assign bus.dbg_state  = state;

    assign mem_we         = bus.wr_en && (state == WR_GRANT);
    assign unused_addr_hi = ^bus.addr[WORD_W-1:ADDR_W];

    l2_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (bus.rd_en),
        .rd_addr (bus.addr[ADDR_W-1:0]),
        .rd_data (bus.rd_data),
        .we      (mem_we),
        .wr_addr (bus.addr[ADDR_W-1:0]),
        .wr_data (bus.wr_data)
    );

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: read beats go through a scoreboard, grants and state are checked inline.
module tb_l2_mem_responder;
  import l2_mem_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int GRANT_DLY = 2;
  localparam int W         = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_mem_responder_if bus();

  l2_mem_responder #(
    .ADDR_W    (ADDR_W),
    .GRANT_DLY (GRANT_DLY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_fail = 0;
  logic beat_taken;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int idx(input logic [W-1:0] a);
    return int'(a[ADDR_W-1:0]);
  endfunction

  // Scoreboard monitor: a beat accepted at a rising edge is compared at the next falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_taken <= 1'b0;
    else        beat_taken <= bus.rd_en & bus.rd_granted;
  end

  always @(negedge clk) begin
    if (beat_taken) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_beat_unexpected: got 0x%08h expected no beat at %0t", bus.rd_data, $time);
      end else begin
        check("rd_beat", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  // All tasks start and end at a falling edge.
  task automatic wait_grant(input bit is_rd, input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((is_rd ? bus.rd_granted : bus.wr_granted) == 1'b0) && lat < 20);
    check(name, 32'(lat), 32'(GRANT_DLY + 1));
  endtask

  task automatic write_words(input logic [W-1:0] base, input int n, input logic [W-1:0] seed);
    bus.wr_req = 1'b1;
    bus.addr   = base;
    wait_grant(1'b0, "wr_grant_latency");
    for (int k = 0; k < n; k++) begin
      bus.addr    = base + 32'(k);
      bus.wr_data = seed + 32'(k);
      bus.wr_en   = 1'b1;
      model_mem[idx(base + 32'(k))] = seed + 32'(k);
      @(negedge clk);
    end
    bus.wr_en  = 1'b0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("wr_granted_release", 32'(bus.wr_granted), 32'd0);
  endtask

  // Leaves rd_en high, parked at the falling edge after the last requested beat.
  task automatic read_beats(input logic [W-1:0] base, input int n);
    bus.rd_en = 1'b1;
    bus.addr  = base;
    wait_grant(1'b1, "rd_grant_latency");
    for (int k = 0; k < n; k++) begin
      check("rd_granted_beat", 32'(bus.rd_granted), 32'd1);
      bus.addr = base + 32'(k);
      exp_q.push_back(model_mem[idx(base + 32'(k))]);
      @(negedge clk);
    end
  endtask

  task automatic read_burst(input logic [W-1:0] base);
    read_beats(base, 8);
    bus.rd_en = 1'b0;
    check("rd_done_grant_low", 32'(bus.rd_granted), 32'd0);
    check("rd_done_state", 32'(bus.dbg_state), 32'(RD_DONE));
    @(negedge clk);
    check("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_en   = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", bus.rd_data, 32'd0);
    check("reset_rd_granted", 32'(bus.rd_granted), 32'd0);
    check("reset_wr_granted", 32'(bus.wr_granted), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Line fill of 0x40..0x47 = 0xA0..0xA7.
    write_words(32'h40, 8, 32'hA0);
    read_burst(32'h40);

    // Write-through of a single word into a known line.
    write_words(32'h120, 8, 32'h120);
    write_words(32'h123, 1, 32'hDEADBEEF);
    read_burst(32'h120);
    check("write_through_model", model_mem[idx(32'h123)], 32'hDEADBEEF);

    // Simultaneous read and write requests: read first, write granted after RD_DONE + IDLE + delay.
    write_words(32'h200, 8, 32'hB00);
    bus.wr_req = 1'b1;
    read_burst(32'h200);
    for (int i = 0; i < GRANT_DLY; i++) begin
      @(negedge clk);
      check("pending_wr_not_granted", 32'(bus.wr_granted), 32'd0);
    end
    @(negedge clk);
    check("pending_wr_granted", 32'(bus.wr_granted), 32'd1);
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("pending_wr_released", 32'(bus.wr_granted), 32'd0);

    // Abort after beat 3, then a full burst must start again from beat 0.
    read_beats(32'h40, 4);
    bus.rd_en = 1'b0;
    @(negedge clk);
    check("abort_grant_low", 32'(bus.rd_granted), 32'd0);
    check("abort_idle", 32'(bus.busy), 32'd0);
    read_burst(32'h40);

    // Reset in the middle of beat 4.
    read_beats(32'h200, 4);
    bus.addr = 32'h204;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rd_data", bus.rd_data, 32'd0);
    check("midreset_rd_granted", 32'(bus.rd_granted), 32'd0);
    check("midreset_wr_granted", 32'(bus.wr_granted), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    bus.rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_burst(32'h200);

    // Aliasing: 0x400.. lands on index 0..7.
    write_words(32'h400, 8, 32'h55);
    read_burst(32'h0);

    // wr_en with no grant must not write index 6.
    bus.addr    = 32'h6;
    bus.wr_data = 32'hBAD0BAD0;
    bus.wr_en   = 1'b1;
    repeat (2) @(negedge clk);
    bus.wr_en   = 1'b0;

    // Same-cycle write and read of index 5: old data first, new data on re-read.
    write_words(32'h5, 1, 32'h11);
    bus.wr_req = 1'b1;
    bus.addr   = 32'h5;
    wait_grant(1'b0, "wr_grant_latency_collision");
    bus.wr_en   = 1'b1;
    bus.wr_data = 32'h77;
    bus.rd_en   = 1'b1;
    @(negedge clk);
    check("collision_old_data", bus.rd_data, 32'h11);
    bus.rd_en  = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_req = 1'b0;
    model_mem[5] = 32'h77;
    @(negedge clk);
    read_burst(32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_mem_responder.md
Name: l2_mem_responder

Overview:
- L2-side responder for the L1 miss-handler read/write protocol.
- Grants the L1 bus to one transaction at a time and serves 8-word line-fill reads with 1-cycle registered read data.
- Accepts single-word write-through stores into a local word-addressed memory.
- Sits between the L1 data-cache miss handler and backing memory; it is the slave end of rd_en/addr/rd_data/granted.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W 32-bit words.
- GRANT_DLY, 2, idle cycles between accepting a request and asserting a grant (0 allowed).
- BURST_LEN, 8, beats per read grant; fixed at 8 to match a 32-byte line.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rd_en  in  1  read request / read beat enable from miss handler.
- wr_req  in  1  write-through request (miss handler's pending write).
- wr_en  in  1  write strobe, legal only while wr_granted.
- addr  in  32  word address; only addr[ADDR_W-1:0] used.
- wr_data  in  32  write data.
- rd_data  out  32  registered read data = mem[addr sampled previous cycle].
- rd_granted  out  1  read bus granted; beats advance while rd_en & rd_granted.
- wr_granted  out  1  write bus granted.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, beat and delay counters 0. Memory contents are not reset. Reset asserted mid-burst aborts immediately; the first request after reset restarts from IDLE.
- FSM states:
  - IDLE: rd_en -> RD_WAIT, else wr_req -> WR_WAIT. Read wins when both are high; the write stays pending and is served after the read completes.
  - RD_WAIT: count GRANT_DLY cycles, then RD_BURST. If rd_en drops here -> IDLE.
  - RD_BURST: rd_granted=1. Each cycle with rd_en=1, beat_cnt (3-bit) increments. When beat_cnt==7 and rd_en=1 -> RD_DONE with beat_cnt wrapping to 0. rd_en=0 mid-burst -> IDLE, rd_granted low the next cycle, beat_cnt cleared.
  - RD_DONE: one cycle, grants low. This turnaround lets the requester see upd_entry. Then -> IDLE.
  - WR_WAIT: count GRANT_DLY, then WR_GRANT. If wr_req drops -> IDLE.
  - WR_GRANT: wr_granted=1 until wr_req drops, then -> IDLE. Every cycle with wr_en=1 writes mem[addr[ADDR_W-1:0]] <= wr_data.
- Grants are registered (Moore outputs). The first granted cycle is GRANT_DLY+1 cycles after rd_en/wr_req rises in IDLE.
- rd_data:
  - Updated every cycle rd_en=1 with mem[addr] from that cycle (1-cycle latency); holds otherwise.
  - Valid regardless of grant, so the requester's beat-0 pre-grant read is harmless.
- Same-cycle write and read to the same index: rd_data returns old contents (read-before-write).
- Address aliasing: addr bits above ADDR_W are ignored; no error response.
- wr_en outside WR_GRANT is ignored (no memory write).
- busy = (state != IDLE).

Decomposition:
- Package l2_mem_pkg holds:
  - state enum l2_rsp_state_t {IDLE, RD_WAIT, RD_BURST, RD_DONE, WR_WAIT, WR_GRANT};
  - localparams WORD_W=32, BURST_LEN=8, BEAT_W=3.
- Sub-module l2_mem_array: synchronous 1R1W RAM (ADDR_W, WORD_W), registered read port, read-before-write. The responder instantiates it and contains only the FSM, counters and grant logic.

Test Plan:
- Reset mid-burst: rst_n low during beat 4 -> rd_granted, wr_granted, busy and rd_data go 0 asynchronously; a new rd_en yields a grant after GRANT_DLY+1 cycles and a full 8-beat burst.
- Line fill: preload mem[0x40..0x47]=0xA0..0xA7, GRANT_DLY=2, rd_en held with addr=0x40+cnt -> rd_granted rises 3 cycles after rd_en; rd_data sequence 0xA0..0xA7, each 1 cycle after its addr; RD_DONE shows one low-grant cycle, then IDLE.
- Write-through: wr_req=1, wr_en=1 in grant, addr=0x123, wr_data=0xDEADBEEF -> after wr_req drops, a read of 0x123 returns 0xDEADBEEF.
- Simultaneous requests: rd_en and wr_req rise together -> read burst completes first; wr_granted asserts only after RD_DONE + IDLE + GRANT_DLY cycles.
- Abort: rd_en drops after beat 3 -> rd_granted 0 next cycle; the next request starts beat_cnt at 0.
- Aliasing and collision: write 0x55 to addr 0x400 (ADDR_W=10) -> read of addr 0 returns 0x55. Same-cycle write 0x77 / read at index 5 holding 0x11 -> rd_data=0x11, then 0x77 on re-read.
